linear_memory_ctrl: RTL and testbench

- Byte-addressed WebAssembly linear-memory controller over one synchronous word-wide RAM.
- Serves 1/2/4/8-byte loads and stores at any byte alignment; a store that crosses a word boundary is split into two RAM accesses by an internal state machine.
- Performs zero/sign extension, bounds checking against the current page count, and `memory.grow`.
- Sits between the execute stage and the on-chip RAM, as the generalised, pipelined successor to the flat combinational-read line memory.

---
 rtl/linear_memory_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_linear_memory_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/linear_memory_ctrl.sv
// Byte-addressed WebAssembly linear-memory controller over one synchronous word-wide RAM.
// Define LINEMEM_BOUNDS_CHECK_EN to build the bounds comparator and illegal-size trap.
module linear_memory_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int PAGE_BYTES = 1024,
  parameter int MAX_PAGES  = 4,
  parameter int INIT_PAGES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  output logic                  trap,
  input  logic                  grow_vld,
  output logic                  grow_rdy,
  input  logic [15:0]           grow_pages,
  output logic                  grow_done,
  output logic [31:0]           grow_result,
  output logic [15:0]           cur_pages
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OW    = $clog2(BYTES);
  localparam int DEPTH = MAX_PAGES * PAGE_BYTES / BYTES;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(PAGE_BYTES);
  localparam logic [1:0] SIZE_MAX = 2'(OW);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, FMT, WR_HI} state_t;

  state_t                    state, state_nxt;
  logic [AW-1:0]             lat_word;
  logic [OW-1:0]             lat_off;
  logic [1:0]                lat_size;
  logic                      lat_signed, lat_span;
  logic [BYTES-1:0]          hi_be;
  logic [DATA_WIDTH-1:0]     hi_data, lo_word, hi_word, ram_q;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  logic [AW-1:0]             req_word, ram_raddr, ram_waddr;
  logic [OW-1:0]             req_off;
  logic [1:0]                eff_size;
  logic [3:0]                req_nbytes;
  logic [4:0]                span_sum;
  logic                      req_span, req_legal, accept, grow_accept, ram_we, top_bit;
  logic [2*BYTES-1:0]        lane_mask, be_wide;
  logic [2*DATA_WIDTH-1:0]   data_wide;
  logic [BYTES-1:0]          ram_be;
  logic [DATA_WIDTH-1:0]     ram_wdata, fmt_src, fmt_data;
  logic [16:0]               grow_sum;

  assign req_rdy     = (state == IDLE);
  assign grow_rdy    = req_rdy & ~req_vld;
  assign accept      = req_vld & req_rdy;
  assign grow_accept = grow_vld & grow_rdy;
  assign grow_sum    = {1'b0, cur_pages} + {1'b0, grow_pages};

  // Decode the incoming request into word index, lane enables and LSB-aligned data lanes.
  always_comb begin
    req_word   = req_addr[AW+OW-1:OW];
    req_off    = req_addr[OW-1:0];
    eff_size   = (req_size > SIZE_MAX) ? SIZE_MAX : req_size;
    req_nbytes = 4'd1 << eff_size;
    span_sum   = 5'(req_off) + 5'(req_nbytes);
    req_span   = span_sum > 5'(BYTES);
    lane_mask  = '0;
    for (int i = 0; i < 2*BYTES; i++)
      lane_mask[i] = (i < int'(req_nbytes));
    be_wide    = lane_mask << req_off;
    data_wide  = {{DATA_WIDTH{1'b0}}, wr_data} << {req_off, 3'b000};
  end

`ifdef LINEMEM_BOUNDS_CHECK_EN
  logic [32:0] end_addr, limit;
  // 33-bit sum so an address that wraps past 2^32 can never look in range.
  always_comb begin
    end_addr  = {1'b0, req_addr} + 33'(req_nbytes);
    limit     = 33'(cur_pages) << PW;
    req_legal = (req_size <= SIZE_MAX) && (end_addr <= limit);
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, req_addr[31:AW+OW]};
  assign req_legal = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    ram_raddr = req_word;
    ram_we    = 1'b0;
    ram_waddr = req_word;
    ram_be    = be_wide[BYTES-1:0];
    ram_wdata = data_wide[DATA_WIDTH-1:0];
    case (state)
      IDLE: begin
        if (accept && req_legal) begin
          if (req_we) begin
            ram_we = 1'b1;
            if (req_span) state_nxt = WR_HI;
          end else begin
            state_nxt = RD_LO;
          end
        end
      end
      RD_LO: begin
        ram_raddr = lat_word + AW'(1);
        state_nxt = lat_span ? RD_HI : FMT;
      end
      RD_HI: state_nxt = FMT;
      FMT:   state_nxt = IDLE;
      WR_HI: begin
        ram_we    = 1'b1;
        ram_waddr = lat_word + AW'(1);
        ram_be    = hi_be;
        ram_wdata = hi_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Align the captured word pair, then zero- or sign-extend above the access size.
  always_comb begin
    fmt_src = DATA_WIDTH'({hi_word, lo_word} >> {lat_off, 3'b000});
    case (lat_size)
      2'd0:    top_bit = fmt_src[7];
      2'd1:    top_bit = fmt_src[15];
      2'd2:    top_bit = fmt_src[31];
      default: top_bit = fmt_src[DATA_WIDTH-1];
    endcase
    fmt_data = '0;
    for (int b = 0; b < BYTES; b++)
      fmt_data[b*8 +: 8] = (b < (1 << lat_size)) ? fmt_src[b*8 +: 8] : {8{top_bit & lat_signed}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_word    <= '0;
      lat_off     <= '0;
      lat_size    <= '0;
      lat_signed  <= 1'b0;
      lat_span    <= 1'b0;
      hi_be       <= '0;
      hi_data     <= '0;
      lo_word     <= '0;
      hi_word     <= '0;
      rd_data     <= '0;
      rd_vld      <= 1'b0;
      trap        <= 1'b0;
      grow_done   <= 1'b0;
      grow_result <= '0;
      cur_pages   <= 16'(INIT_PAGES);
    end else begin
      state     <= state_nxt;
      rd_vld    <= 1'b0;
      trap      <= 1'b0;
      grow_done <= 1'b0;
      if (accept) begin
        lat_word   <= req_word;
        lat_off    <= req_off;
        lat_size   <= eff_size;
        lat_signed <= req_signed;
        lat_span   <= req_span;
        hi_be      <= be_wide[2*BYTES-1:BYTES];
        hi_data    <= data_wide[2*DATA_WIDTH-1:DATA_WIDTH];
        trap       <= ~req_legal;
      end
      if (state == RD_LO) lo_word <= ram_q;
      if (state == RD_HI) hi_word <= ram_q;
      if (state == FMT) begin
        rd_data <= fmt_data;
        rd_vld  <= 1'b1;
      end
      if (grow_accept) begin
        grow_done <= 1'b1;
        if (grow_sum <= 17'(MAX_PAGES)) begin
          grow_result <= {16'b0, cur_pages};
          cur_pages   <= grow_sum[15:0];
        end else begin
          grow_result <= '1;
        end
      end
    end
  end

  // RAM is deliberately unreset so grown pages keep whatever they held.
  always_ff @(posedge clk) begin
    ram_q <= mem[ram_raddr];
    if (ram_we) begin
      for (int b = 0; b < BYTES; b++)
        if (ram_be[b]) mem[ram_waddr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_linear_memory_ctrl.sv
// Randomized self-checking bench for linear_memory_ctrl.
// Reference model is a flat byte array of linear memory plus a page counter.
module tb_linear_memory_ctrl;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int PAGE  = 1024;
  localparam int MAXP  = 4;
  localparam int INITP = 1;
  localparam int MEMB  = MAXP * PAGE;
`ifdef LINEMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic          clk, rst_n;
  logic          req_vld, req_rdy, req_we, req_signed;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_vld, trap;
  logic          grow_vld, grow_rdy, grow_done;
  logic [15:0]   grow_pages, cur_pages;
  logic [31:0]   grow_result;

  logic [7:0]    mem_m [MEMB];
  bit            known_m [MEMB];
  int            pages_m;
  int            vectors, miscompares;
  logic [31:0]   got;
  bit            seen;

  linear_memory_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .wr_data(wr_data),
    .rd_data(rd_data), .rd_vld(rd_vld), .trap(trap),
    .grow_vld(grow_vld), .grow_rdy(grow_rdy), .grow_pages(grow_pages),
    .grow_done(grow_done), .grow_result(grow_result), .cur_pages(cur_pages)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One access from a negedge; returns at a negedge with the controller idle again.
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [1:0] size,
                               input bit sgn, input logic [31:0] data, output logic [31:0] result);
    int          n, lat, idx;
    bit          legal, span, all_known, quiet;
    logic [63:0] end_a, exp_v;
    n     = (size == 2'd3) ? NB : (1 << size);
    end_a = {32'b0, addr} + 64'(n);
    legal = !BOUNDS_EN || ((size != 2'd3 || NB == 8) && (end_a <= 64'(pages_m) * 64'(PAGE)));
    span  = (int'(addr % 32'(NB)) + n) > NB;
    req_vld = 1'b1; req_we = we; req_addr = addr; req_size = size; req_signed = sgn; wr_data = data;
    #1 checkOutput("grow_rdy_blocked", grow_rdy, 0);
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    result  = '0;
    checkOutput("trap", trap, !legal);
    if (!legal) begin
      checkOutput("trap_rdy", req_rdy, 1);
      quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (rd_vld || trap) quiet = 1'b0;
      end
      checkOutput("trap_quiet", quiet, 1);
    end else if (we) begin
      checkOutput("st_rdy", req_rdy, !span);
      if (span) begin
        @(negedge clk);
        checkOutput("st_hi_rdy", req_rdy, 1);
      end
      for (int k = 0; k < n; k++) begin
        idx = int'((addr + 32'(k)) % 32'(MEMB));
        mem_m[idx]   = data[8*k +: 8];
        known_m[idx] = 1'b1;
      end
    end else begin
      lat = 0;
      while (!rd_vld && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      checkOutput("ld_latency", lat, span ? 3 : 2);
      result    = rd_data;
      exp_v     = '0;
      all_known = 1'b1;
      for (int k = 0; k < n; k++) begin
        idx = int'((addr + 32'(k)) % 32'(MEMB));
        exp_v[8*k +: 8] = mem_m[idx];
        if (!known_m[idx]) all_known = 1'b0;
      end
      if (sgn && n < NB && exp_v[8*n-1])
        for (int k = n; k < NB; k++) exp_v[8*k +: 8] = 8'hFF;
      if (all_known) checkOutput("ld_data", rd_data, exp_v);
      @(negedge clk);
      checkOutput("ld_pulse", rd_vld, 0);
    end
  endtask

  task automatic applyGrow(input logic [15:0] delta, output logic [31:0] result);
    logic [31:0] exp_r;
    if (pages_m + int'(delta) <= MAXP) begin
      exp_r   = 32'(pages_m);
      pages_m = pages_m + int'(delta);
    end else begin
      exp_r = 32'hFFFF_FFFF;
    end
    grow_vld = 1'b1; grow_pages = delta;
    #1 checkOutput("grow_rdy", grow_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    grow_vld = 1'b0;
    checkOutput("grow_done", grow_done, 1);
    checkOutput("grow_result", grow_result, exp_r);
    checkOutput("cur_pages", cur_pages, pages_m);
    result = grow_result;
    @(negedge clk);
    checkOutput("grow_pulse", grow_done, 0);
  endtask

  initial begin
    int          r;
    logic [1:0]  sz;
    logic [31:0] a;
    vectors = 0; miscompares = 0; pages_m = INITP;
    rst_n = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; wr_data = '0; grow_vld = 1'b0; grow_pages = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_rdy", req_rdy, 1);
    checkOutput("rst_grow_rdy", grow_rdy, 1);
    checkOutput("rst_rd_vld", rd_vld, 0);
    checkOutput("rst_trap", trap, 0);
    checkOutput("rst_grow_done", grow_done, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_grow_result", grow_result, 0);
    checkOutput("rst_cur_pages", cur_pages, INITP);

    // Fill page 0 with back-to-back aligned stores so later loads have known contents.
    for (int w = 0; w < PAGE/NB; w++)
      applyStimulus(1'b1, 32'(w*NB), 2'd2, 1'b0, $urandom, got);

    applyStimulus(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, got);
    applyStimulus(1'b0, 32'h10, 2'd2, 1'b0, '0, got);
    checkOutput("plan_aligned", got, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h13, 2'd0, 1'b1, '0, got);
    checkOutput("plan_sext", got, 32'hFFFFFFDE);
    applyStimulus(1'b0, 32'h13, 2'd0, 1'b0, '0, got);
    checkOutput("plan_zext", got, 32'h000000DE);
    applyStimulus(1'b1, 32'h1E, 2'd2, 1'b0, 32'h11223344, got);
    applyStimulus(1'b0, 32'h1E, 2'd2, 1'b0, '0, got);
    checkOutput("plan_span", got, 32'h11223344);
    applyStimulus(1'b0, 32'h1C, 2'd2, 1'b0, '0, got);
    checkOutput("plan_word1c", got[31:16], 16'h3344);
    applyStimulus(1'b0, 32'h20, 2'd2, 1'b0, '0, got);
    checkOutput("plan_word20", got[15:0], 16'h1122);
    applyStimulus(1'b0, 32'd1022, 2'd2, 1'b0, '0, got);
    applyStimulus(1'b0, 32'd1020, 2'd2, 1'b0, '0, got);
    applyStimulus(1'b0, 32'h10, 2'd3, 1'b0, '0, got);
    applyStimulus(1'b0, 32'hFFFF_FFFE, 2'd2, 1'b0, '0, got);

    applyGrow(16'd2, got);
    checkOutput("plan_grow_ok", got, 32'd1);
    checkOutput("plan_pages3", cur_pages, 16'd3);
    applyGrow(16'd2, got);
    checkOutput("plan_grow_fail", got, 32'hFFFF_FFFF);
    applyGrow(16'hFFFF, got);
    applyStimulus(1'b0, 32'd2100, 2'd2, 1'b0, '0, got);
    applyStimulus(1'b1, 32'd2100, 2'd2, 1'b0, 32'hCAFE0123, got);
    applyStimulus(1'b0, 32'd2100, 2'd2, 1'b0, '0, got);
    checkOutput("plan_grown_page", got, 32'hCAFE0123);

    // Abort a spanning load while it sits in RD_HI.
    req_vld = 1'b1; req_we = 1'b0; req_addr = 32'h1E; req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_rdy", req_rdy, 1);
    checkOutput("rst_mid_pages", cur_pages, INITP);
    checkOutput("rst_mid_vld", rd_vld, 0);
    pages_m = INITP;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rd_vld) seen = 1'b1;
    end
    checkOutput("rst_mid_no_vld", seen, 0);

    for (int t = 0; t < 400; t++) begin
      r = int'($urandom_range(0, 19));
      if (r == 19) begin
        applyGrow(16'($urandom_range(0, 3)), got);
      end else begin
        sz = (r % 10 == 9) ? 2'd3 : 2'(r % 3);
        r  = int'($urandom_range(0, 9));
        if (r < 7)      a = 32'($urandom_range(0, PAGE - 1));
        else if (r < 9) a = 32'(pages_m*PAGE - 8 + int'($urandom_range(0, 15)));
        else            a = $urandom;
        applyStimulus(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
